// File: rtl/dm_refill_responder_pkg.sv
// Constants and state encoding shared by the refill responder and the cache controller.
// Word width and block geometry must match on both sides of the data-memory handshake.
package dm_refill_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int OFF_W       = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_RD_BURST = 2'd2,
        S_WR       = 2'd3
    } state_t;

endpackage

// File: rtl/dm_refill_responder_if.sv
// Data-memory request/response bundle between the cache controller (master) and memory (slave).
// Requests are levels held until the one-cycle ready pulse; there is no other backpressure.
interface dm_refill_responder_if
    import dm_refill_responder_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              dm_re;
    logic              dm_we;
    logic [ADDR_W-1:0] addr;
    word_t             wd;
    word_t             rd;
    logic [OFF_W-1:0]  word_offset;
    logic              word_valid;
    logic              ready;
    logic              busy;

    modport master (
        output dm_re, dm_we, addr, wd,
        input  rd, word_offset, word_valid, ready, busy
    );

    modport slave (
        input  dm_re, dm_we, addr, wd,
        output rd, word_offset, word_valid, ready, busy
    );

endinterface

// File: rtl/dm_refill_responder_dm_array.sv
// Backing word store: synchronous write, asynchronous read, contents survive reset.
// Zero-cycle read latency; the port never stalls.
module dm_array
    import dm_refill_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  word_t             i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output word_t             o_rdat
);

    word_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/dm_refill_responder.sv
// Multi-cycle main memory: 4-word block refills and single-word write-through after LATENCY waits.
// Read ready lands LATENCY+3 cycles after acceptance, write ready after LATENCY; requests held until ready.
module dm_refill_responder
    import dm_refill_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_refill_responder_if.slave bus
);

    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [OFF_W-1:0]  r_beat;
    logic [OFF_W-1:0]  w_beat_nxt;
    logic [ADDR_W-1:0] r_addr;
    word_t             r_wd;
    logic              r_is_wr;
    logic              w_accept;
    logic              w_in_burst;
    word_t             w_rdat;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Write has priority; a simultaneous read request is dropped.
                if (bus.dm_we || bus.dm_re) begin
                    w_accept   = 1'b1;
                    w_cnt_nxt  = '0;
                    w_beat_nxt = '0;
                    if (LATENCY > 0) begin
                        w_state_nxt = S_WAIT;
                    end else if (bus.dm_we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD_BURST;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_state_nxt = r_is_wr ? S_WR : S_RD_BURST;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_BURST: begin
                w_beat_nxt = r_beat + 1'b1;
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_is_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_addr  <= bus.addr;
                r_wd    <= bus.wd;
                r_is_wr <= bus.dm_we;
            end
        end
    end

    // Commit happens only on the edge leaving WR, so a reset earlier abandons the write.
    dm_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dm_array (
        .clk     (clk),
        .i_we    (r_state == S_WR),
        .i_waddr (r_addr),
        .i_wdat  (r_wd),
        .i_raddr ({r_addr[ADDR_W-1:OFF_W], r_beat}),
        .o_rdat  (w_rdat)
    );

    assign w_in_burst      = (r_state == S_RD_BURST);
    assign bus.word_valid  = w_in_burst;
    assign bus.word_offset = w_in_burst ? r_beat : '0;
    assign bus.rd          = w_in_burst ? w_rdat : '0;
    assign bus.ready       = (r_state == S_WR) || (w_in_burst && (r_beat == LAST_BEAT));
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_refill_responder.sv
// Scoreboarded bench for two responders (LATENCY=4 as unit 0, LATENCY=0 as unit 1).
module tb_dm_refill_responder;
    import dm_refill_responder_pkg::*;

    typedef struct {
        int        cyc;
        bit        wv;
        bit        rdy;
        bit [1:0]  off;
        bit [31:0] dat;
        bit        chkd;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_refill_responder_if #(.ADDR_W(10)) if4 ();
    dm_refill_responder_if #(.ADDR_W(10)) if0 ();

    dm_refill_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    dm_refill_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    int   cyc  = 0;
    int   nerr = 0;
    int   nchk = 0;
    bit   run  = 1'b0;
    int   bfrom[2] = '{1, 1};
    int   bto[2]   = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];
    bit [31:0] mdl   [2][1024];
    bit        known [2][1024];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int z);
        return (z == 1) ? 0 : 4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void push(int z, exp_t e);
        if (z == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    task automatic drv(int z, bit we, bit re, logic [9:0] a, logic [31:0] d);
        if (z == 0) begin
            if4.dm_we = we; if4.dm_re = re; if4.addr = a; if4.wd = d;
        end else begin
            if0.dm_we = we; if0.dm_re = re; if0.addr = a; if0.wd = d;
        end
    endtask

    function automatic logic get_rdy(int z);
        return (z == 0) ? if4.ready : if0.ready;
    endfunction

    task automatic mon(int z, logic wv, logic rdy, logic [1:0] off, logic [31:0] rd, logic bsy);
        exp_t e;
        bit   have;
        chk($sformatf("busy u%0d cyc %0d", z, cyc), 32'(bsy), 32'(cyc >= bfrom[z] && cyc <= bto[z]));
        if (wv === 1'b1 || rdy === 1'b1) begin
            have = 1'b0;
            if (z == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (z == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                chk($sformatf("unexpected output u%0d cyc %0d", z, cyc), 32'({wv, rdy}), 32'd0);
            end else begin
                chk($sformatf("event cycle u%0d", z), 32'(cyc), 32'(e.cyc));
                chk($sformatf("word_valid u%0d cyc %0d", z, cyc), 32'(wv), 32'(e.wv));
                chk($sformatf("ready u%0d cyc %0d", z, cyc), 32'(rdy), 32'(e.rdy));
                if (e.wv) chk($sformatf("word_offset u%0d cyc %0d", z, cyc), 32'(off), 32'(e.off));
                if (e.wv && e.chkd) chk($sformatf("rd u%0d off %0d cyc %0d", z, e.off, cyc), rd, e.dat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            mon(0, if4.word_valid, if4.ready, if4.word_offset, if4.rd, if4.busy);
            mon(1, if0.word_valid, if0.ready, if0.word_offset, if0.rd, if0.busy);
        end
    end

    // Called one step after a rising edge with the addressed unit idle; returns likewise.
    task automatic issue(int z, bit we, bit re, logic [9:0] a, logic [31:0] d, bit scr);
        int   e_cyc;
        int   base;
        int   n;
        exp_t e;
        drv(z, we, re, a, d);
        @(posedge clk); #1;
        e_cyc    = cyc;
        bfrom[z] = e_cyc;
        if (we) begin
            e.cyc = e_cyc + lat(z); e.wv = 1'b0; e.rdy = 1'b1;
            e.off = 2'd0; e.dat = 32'd0; e.chkd = 1'b0;
            push(z, e);
            mdl[z][a]   = d;
            known[z][a] = 1'b1;
            bto[z]      = e_cyc + lat(z);
        end else begin
            base = int'(a) / 4 * 4;
            for (int k = 0; k < 4; k++) begin
                e.cyc  = e_cyc + lat(z) + k;
                e.wv   = 1'b1;
                e.rdy  = (k == 3);
                e.off  = 2'(k);
                e.dat  = mdl[z][base + k];
                e.chkd = known[z][base + k];
                push(z, e);
            end
            bto[z] = e_cyc + lat(z) + 3;
        end
        n = 0;
        while (get_rdy(z) !== 1'b1 && n < 40) begin
            if (scr) drv(z, 1'($urandom), 1'($urandom), 10'($urandom), $urandom);
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk($sformatf("ready timeout u%0d", z), 32'(get_rdy(z)), 32'd1);
        @(posedge clk); #1;
        drv(z, 1'b0, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, " busy u0"}, 32'(if4.busy), 32'd0);
        chk({tag, " word_valid u0"}, 32'(if4.word_valid), 32'd0);
        chk({tag, " ready u0"}, 32'(if4.ready), 32'd0);
        chk({tag, " word_offset u0"}, 32'(if4.word_offset), 32'd0);
        chk({tag, " rd u0"}, if4.rd, 32'd0);
        chk({tag, " busy u1"}, 32'(if0.busy), 32'd0);
        chk({tag, " word_valid u1"}, 32'(if0.word_valid), 32'd0);
        chk({tag, " ready u1"}, 32'(if0.ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 1'b0, 1'b0, 10'd0, 32'd0);
        drv(1, 1'b0, 1'b0, 10'd0, 32'd0);
        reset = 1'b0;
        #12;
        chk_idle("reset");
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run = 1'b1;

        // Unit 0 (LATENCY=4): write then block read seeing the new word at offset 3.
        issue(0, 1, 0, 10'h010, 32'h000000A0, 0);
        issue(0, 1, 0, 10'h011, 32'h000000A1, 0);
        issue(0, 1, 0, 10'h012, 32'h000000A2, 0);
        issue(0, 1, 0, 10'h013, 32'hDEADBEEF, 0);
        issue(0, 0, 1, 10'h010, 32'd0, 0);
        issue(0, 1, 0, 10'h013, 32'h000000A3, 0);
        issue(0, 0, 1, 10'h012, 32'd0, 1);

        // Simultaneous write and read: only the write happens.
        issue(0, 1, 1, 10'h020, 32'h00000055, 0);
        issue(0, 0, 1, 10'h020, 32'd0, 0);

        // Reset during WAIT of a write must leave the old value in place.
        issue(0, 1, 0, 10'h030, 32'h00000011, 0);
        drv(0, 1'b1, 1'b0, 10'h030, 32'h00000077);
        @(posedge clk); #1;
        bfrom[0] = cyc;
        bto[0]   = cyc + 4;
        @(posedge clk); #2;
        reset    = 1'b0;
        bfrom[0] = 1;
        bto[0]   = 0;
        #1;
        chk_idle("async reset");
        drv(0, 1'b0, 1'b0, 10'd0, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(0, 0, 1, 10'h030, 32'd0, 0);

        // Back-to-back read then write with request noise while busy.
        issue(0, 0, 1, 10'h010, 32'd0, 1);
        issue(0, 1, 0, 10'h011, 32'h000000B1, 1);
        issue(0, 0, 1, 10'h010, 32'd0, 0);

        // Unit 1 (LATENCY=0).
        for (int k = 0; k < 4; k++) issue(1, 1, 0, 10'(32'h040 + k), 32'hC0 + k, 0);
        issue(1, 0, 1, 10'h041, 32'd0, 1);
        issue(1, 1, 0, 10'h042, 32'h000000C7, 0);
        issue(1, 0, 1, 10'h040, 32'd0, 0);
        issue(1, 1, 1, 10'h043, 32'h000000C9, 1);
        issue(1, 0, 1, 10'h043, 32'd0, 0);

        // Randomized traffic on a preloaded window of both units.
        for (int z = 0; z < 2; z++) begin
            for (int k = 0; k < 16; k++) issue(z, 1, 0, 10'(32'h100 + k), $urandom, 0);
            for (int i = 0; i < 40; i++) begin
                int kind;
                kind = $urandom_range(0, 2);
                issue(z, kind != 1, kind != 0, 10'(32'h100 + $urandom_range(0, 15)), $urandom,
                      1'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("leftover expectations u0", 32'(q0.size()), 32'd0);
        chk("leftover expectations u1", 32'(q1.size()), 32'd0);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dm_refill_responder.md
Name: dm_refill_responder

Overview:
- Memory-side responder for the cache controller's data-memory requests (dm_we / dm_re / ready / word_offset handshake).
- Serves each read as a 4-word block refill: one word per cycle, tagged with word_offset, after a programmable access latency.
- Serves each write as a single-word write-through, completed after the same latency.
- Replaces the single-cycle data memory with a realistic multi-cycle main memory.

Parameters:
- ADDR_W, 10, word-address width.
- DEPTH, 1024, words in the backing array (2**ADDR_W).
- LATENCY, 4, wait cycles between request acceptance and the first data beat or write commit; 0 is legal.
- BLOCK_WORDS, 4, words per refill block; fixed, with word_offset 2 bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dm_re  in  1  block-read request, level, held by the controller until ready.
- dm_we  in  1  word-write request, level, held until ready.
- addr  in  ADDR_W  word address of the request.
- wd  in  32  write data.
- rd  out  32  refill data beat.
- word_offset  out  2  index of the current beat within the block.
- word_valid  out  1  high on each refill beat; the cache writes on this.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from acceptance through the ready cycle.

Behaviour:
- Reset (reset=0), immediate and asynchronous:
  - state=IDLE; rd=0, word_offset=0, word_valid=0, ready=0, busy=0; latency counter and beat counter cleared.
  - Array contents are not cleared and persist across reset.
- States: IDLE, WAIT, RD_BURST, WR.
- IDLE:
  - Samples dm_re/dm_we each edge.
  - dm_we=1 wins over dm_re, so simultaneous requests perform the write only.
  - On acceptance, latch base={addr[ADDR_W-1:2],2'b00}, word index addr[1:0], and wd.
  - Next state is WAIT if LATENCY>0; otherwise RD_BURST (read) or WR (write).
  - busy goes high on the next cycle.
- WAIT:
  - Counts LATENCY cycles, then goes to RD_BURST or WR according to the latched request type.
- RD_BURST:
  - 4 consecutive cycles, beat k=0..3.
  - Outputs word_valid=1, word_offset=k, rd=mem[base+k]. Order is always 0..3, not critical-word-first.
  - ready=1 coincident with beat 3; then IDLE.
- WR:
  - 1 cycle with ready=1.
  - mem[latched addr] <= latched wd at the edge leaving WR; then IDLE.
- Latency from the accepting edge:
  - Read: first beat after LATENCY cycles; ready LATENCY+3 cycles later.
  - Write: ready after LATENCY cycles.
- Handshake:
  - dm_re/dm_we and addr/wd changes while busy are ignored; only the latched request is used.
  - The controller drops its request on the edge that samples ready, so IDLE never re-triggers on a stale request.
  - A new request asserted in the cycle after ready is accepted normally (back-to-back).
- Reset mid-operation: the transaction is abandoned and no partial write is committed, since the commit happens only at the WR exit edge. Beats already delivered stand.
- Outputs are registered from state; no combinational path from the request inputs to the outputs.
- addr wrap: base+k never crosses a block boundary.

Decomposition:
- Shared package holds:
  - State encoding localparams S_IDLE/S_WAIT/S_RD_BURST/S_WR.
  - WORD_W=32 and BLOCK_WORDS=4; the cache controller uses the same constants.
- One natural sub-module, dm_array:
  - DEPTH x 32.
  - Synchronous write, asynchronous read.
  - No reset.

Test Plan:
- Reset: pulse reset low mid-cycle -> all outputs 0 asynchronously, before the next clk edge; busy=0.
- Write, LATENCY=4: dm_we=1, addr=0x013, wd=0xDEADBEEF accepted at edge E -> busy high for 5 cycles, ready pulses once; a later read of block 0x010 returns 0xDEADBEEF at word_offset 3.
- Block read, LATENCY=4:
  - Preload 0x010..0x013 = 0xA0,0xA1,0xA2,0xA3; dm_re=1, addr=0x012.
  - -> word_valid high on 4 consecutive cycles, first beat 4 cycles after acceptance.
  - word_offset 0,1,2,3 with rd 0xA0..0xA3; ready only with offset 3.
- Simultaneous dm_we=dm_re=1, addr=0x020, wd=0x55 -> only the write is performed: no word_valid beats, ready after the write latency, mem[0x020]=0x55.
- Reset during WAIT of a write of 0x77 to 0x030 (old value 0x11) -> reads of 0x030 still return 0x11; the next request after reset is serviced normally.
- Back-to-back, plus a LATENCY=0 instance:
  - Read, then a write asserted the cycle after ready -> both serviced, and dm_re toggling mid-burst has no effect.
  - LATENCY=0 -> first beat the cycle after acceptance.
